// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky error flags
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun_err,
  input  logic                          err_clear,
  output logic                          irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic push, ferr_set, tick;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, full, wr, ovr_set;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {rx_i, rx_m};
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  always_comb begin
    tick     = cnt == '0;
    state_n  = state;
    cnt_n    = tick ? cnt : cnt - 1'b1;
    idx_n    = idx;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = HALF;
      end
      START: if (tick) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n   = FULL;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        sh_n    = {rx_s, sh[7:1]};
        cnt_n   = FULL;
        idx_n   = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      // leaving at mid-stop-bit lets a back-to-back start edge be caught
      STOP: if (tick) begin
        push     = rx_s;
        ferr_set = !rx_s;
        state_n  = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
  assign rx_valid = fifo_count != '0;
  assign irq      = rx_valid;
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign pop      = rx_valid && rx_ready;
  assign full     = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign wr       = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  always_ff @(posedge wb_clk_i)
    if (wr) mem[wr_ptr] <= sh;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      wr_ptr      <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_count  <= fifo_count + (AW+1)'(wr) - (AW+1)'(pop);
      frame_err   <= ferr_set ? 1'b1 : err_clear ? 1'b0 : frame_err;
      overrun_err <= ovr_set ? 1'b1 : err_clear ? 1'b0 : overrun_err;
    end
endmodule
